// File: rtl/spiral_pkg.sv
// Shared widths and helpers for the spiral shader: radius approximation and
// arm-index-to-colour palette.
package spiral_pkg;

   localparam int XY_W    = 7;
   localparam int PH_W    = 4;
   localparam int RGB_W   = 6;
   localparam int FRAME_W = 8;

   // Arm index k maps to {R,G,B} = {k[3:2], k[1:0], ~k[3:2]}
   function automatic logic [RGB_W-1:0] spiral_palette(input logic [PH_W-1:0] k);
      return {k[3:2], k[1:0], ~k[3:2]};
   endfunction

   // Two's-complement magnitude; -64 comes out as 64 in the unsigned result
   function automatic logic [XY_W-1:0] abs_xy(input logic [XY_W-1:0] v);
      return v[XY_W-1] ? (~v + XY_W'(1)) : v;
   endfunction

   function automatic logic [XY_W-1:0] approx_radius(input logic [XY_W-1:0] ax,
                                                     input logic [XY_W-1:0] ay);
      logic [XY_W-1:0] hi;
      logic [XY_W-1:0] lo;
      hi = (ax >= ay) ? ax : ay;
      lo = (ax >= ay) ? ay : ax;
      return hi + (lo >> 1);
   endfunction

endpackage

// File: rtl/spiral_shader_if.sv
// Pixel-side bundle of the spiral shader: ce, x/y, timing and CORDIC phase in,
// colour and aligned timing out.
interface spiral_shader_if;
   import spiral_pkg::*;

   logic               i_ce;
   logic [XY_W-1:0]    i_xval;
   logic [XY_W-1:0]    i_yval;
   logic               i_hsync;
   logic               i_vsync;
   logic               i_de;
   logic [PH_W-1:0]    i_phase;
   logic [RGB_W-1:0]   o_rgb;
   logic               o_hsync;
   logic               o_vsync;
   logic               o_de;

   modport master (
      output i_ce, i_xval, i_yval, i_hsync, i_vsync, i_de, i_phase,
      input  o_rgb, o_hsync, o_vsync, o_de
   );

   modport slave (
      input  i_ce, i_xval, i_yval, i_hsync, i_vsync, i_de, i_phase,
      output o_rgb, o_hsync, o_vsync, o_de
   );

endinterface

// File: rtl/spiral_delay.sv
// ce-gated shift-register delay line with synchronous active-low clear;
// DEPTH=0 degenerates to a plain wire.
module spiral_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_ce,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign o_q = i_d;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge i_clk) begin
            if (!i_reset_n) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else if (i_ce) begin
               stage[0] <= i_d;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign o_q = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/spiral_shader.sv
// Spiral shader behind the rect-to-polar CORDIC: aligns x/y/timing to the phase,
// forms an animated arm index and maps it to 6-bit RGB. Option: SPIRAL_CENTER_DOT_EN.
module spiral_shader
   import spiral_pkg::*;
#(
   parameter int CORDIC_LAT  = 5,
   parameter int RAD_SHIFT   = 3,
   parameter int SPEED_SHIFT = 2
`ifdef SPIRAL_CENTER_DOT_EN
   ,
   parameter int CENTER_R    = 6
`endif
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   spiral_shader_if.slave  bus
);

   logic [XY_W-1:0]    ax_q;
   logic [XY_W-1:0]    ay_q;
   logic [XY_W-1:0]    r_q;
   logic [XY_W-1:0]    r_d;
   logic [2:0]         tim_d;
   logic [FRAME_W-1:0] frame_cnt;
   logic               vs_q;
   logic [PH_W-1:0]    arm_sum;
   logic [PH_W-1:0]    s_q;
   logic               hs_a;
   logic               vs_a;
   logic               de_a;
   logic [RGB_W-1:0]   rgb_next;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         ax_q <= '0;
         ay_q <= '0;
         r_q  <= '0;
      end else if (bus.i_ce) begin
         ax_q <= abs_xy(bus.i_xval);
         ay_q <= abs_xy(bus.i_yval);
         r_q  <= approx_radius(ax_q, ay_q);
      end
   end

   // Radius is ready after two stages; the rest of the CORDIC latency is padded here
   spiral_delay #(.WIDTH(XY_W), .DEPTH(CORDIC_LAT-2)) u_r_delay (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(bus.i_ce), .i_d(r_q), .o_q(r_d)
   );

   spiral_delay #(.WIDTH(3), .DEPTH(CORDIC_LAT)) u_tim_delay (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(bus.i_ce),
      .i_d({bus.i_hsync, bus.i_vsync, bus.i_de}), .o_q(tim_d)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         vs_q      <= 1'b0;
         frame_cnt <= '0;
      end else if (bus.i_ce) begin
         vs_q <= bus.i_vsync;
         if (bus.i_vsync && !vs_q) frame_cnt <= frame_cnt + FRAME_W'(1);
      end
   end

   // Carries out of the 4-bit sum are dropped so the arm index wraps mod 16
   assign arm_sum = bus.i_phase + r_d[RAD_SHIFT +: PH_W] + frame_cnt[SPEED_SHIFT +: PH_W];

`ifdef SPIRAL_CENTER_DOT_EN
   logic [XY_W-1:0] r_a;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) r_a <= '0;
      else if (bus.i_ce) r_a <= r_d;
   end
`else
   logic unused_radius;
   assign unused_radius = ^r_d[RAD_SHIFT-1:0];
`endif

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         s_q  <= '0;
         hs_a <= 1'b0;
         vs_a <= 1'b0;
         de_a <= 1'b0;
      end else if (bus.i_ce) begin
         s_q                <= arm_sum;
         {hs_a, vs_a, de_a} <= tim_d;
      end
   end

   always_comb begin
      rgb_next = '0;
      if (de_a) begin
         rgb_next = spiral_palette(s_q);
`ifdef SPIRAL_CENTER_DOT_EN
         if (r_a < XY_W'(CENTER_R)) rgb_next = '1;
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         bus.o_rgb   <= '0;
         bus.o_hsync <= 1'b0;
         bus.o_vsync <= 1'b0;
         bus.o_de    <= 1'b0;
      end else if (bus.i_ce) begin
         bus.o_rgb   <= rgb_next;
         bus.o_hsync <= hs_a;
         bus.o_vsync <= vs_a;
         bus.o_de    <= de_a;
      end
   end

endmodule

// File: tb/tb_spiral_shader.sv
// Directed bench for spiral_shader: reset/flush, 7-cycle alignment, radius,
// blanking, ce stalls, centre dot (SPIRAL_CENTER_DOT_EN) and frame animation.
module tb_spiral_shader;
   import spiral_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checkCount = 0;
   int   errorCount = 0;

   always #5 clk = ~clk;

   spiral_shader_if bus ();

   spiral_shader dut (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .bus       (bus)
   );

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, then sample point lands 1ns after the edge
   task automatic applyStimulus(input logic ce, input logic [6:0] x, input logic [6:0] y,
                                input logic hs, input logic vs, input logic de, input logic [3:0] ph);
      bus.i_ce    = ce;
      bus.i_xval  = x;
      bus.i_yval  = y;
      bus.i_hsync = hs;
      bus.i_vsync = vs;
      bus.i_de    = de;
      bus.i_phase = ph;
      @(posedge clk);
      #1;
   endtask

   task automatic applyGarbage(input logic ce);
      applyStimulus(ce, 7'($urandom), 7'($urandom), 1'b1, 1'b1, 1'b1, 4'($urandom));
   endtask

   // One pixel, its phase 5 ce-cycles later, result expected on the 7th ce-edge
   task automatic runPixel(input string tag, input logic [6:0] x, input logic [6:0] y,
                           input logic hs, input logic de, input logic [3:0] ph,
                           input bit stall, input logic [5:0] expRgb);
      applyStimulus(1'b1, x, y, hs, 1'b0, de, 4'd0);
      if (stall) repeat (2) applyGarbage(1'b0);
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(1'b1, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, (k == 5) ? ph : 4'd0);
         if (k == 5) checkOutput({tag, "_early_de"}, {7'd0, bus.o_de}, 8'd0);
      end
      checkOutput({tag, "_rgb"}, {2'd0, bus.o_rgb}, {2'd0, expRgb});
      checkOutput({tag, "_de"},  {7'd0, bus.o_de},    {7'd0, de});
      checkOutput({tag, "_hs"},  {7'd0, bus.o_hsync}, {7'd0, hs});
      if (stall) begin
         repeat (2) applyGarbage(1'b0);
         checkOutput({tag, "_hold_rgb"}, {2'd0, bus.o_rgb}, {2'd0, expRgb});
         checkOutput({tag, "_hold_de"},  {7'd0, bus.o_de},  {7'd0, de});
      end
      applyStimulus(1'b1, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      checkOutput({tag, "_after_de"}, {7'd0, bus.o_de}, 8'd0);
   endtask

   task automatic pulseVsync(input int n);
      repeat (n) begin
         applyStimulus(1'b1, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, 4'd0);
         applyStimulus(1'b1, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      end
   endtask

   initial begin
      logic [5:0] expCenter;

      // Reset held with random traffic
      reset_n = 1'b0;
      repeat (4) applyGarbage(1'b1);
      checkOutput("rst_rgb", {2'd0, bus.o_rgb}, 8'd0);
      checkOutput("rst_hs",  {7'd0, bus.o_hsync}, 8'd0);
      checkOutput("rst_vs",  {7'd0, bus.o_vsync}, 8'd0);
      checkOutput("rst_de",  {7'd0, bus.o_de}, 8'd0);

      reset_n = 1'b1;
      for (int c = 0; c < 7; c++) begin
         checkOutput("release_de", {7'd0, bus.o_de}, 8'd0);
         applyStimulus(1'b1, 7'd40, 7'd0, 1'b1, 1'b0, 1'b1, 4'd0);
      end
      checkOutput("release_de_on", {7'd0, bus.o_de}, 8'd1);
      checkOutput("release_hs_on", {7'd0, bus.o_hsync}, 8'd1);

      // Mid-stream reset must flush the de=1 pixels already in flight
      reset_n = 1'b0;
      applyStimulus(1'b1, 7'd40, 7'd0, 1'b1, 1'b0, 1'b1, 4'd0);
      checkOutput("midrst_de", {7'd0, bus.o_de}, 8'd0);
      checkOutput("midrst_hs", {7'd0, bus.o_hsync}, 8'd0);
      reset_n = 1'b1;
      for (int c = 0; c < 7; c++) begin
         applyStimulus(1'b1, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 4'd0);
         checkOutput("flush_de", {7'd0, bus.o_de}, 8'd0);
      end

      runPixel("align",    7'd40,        7'd0,        1'b0, 1'b1, 4'd4, 1'b0, 6'b100101);
      runPixel("rad_50",   7'b1011000,   7'd20,       1'b0, 1'b1, 4'd0, 1'b0, 6'b011010);
      runPixel("rad_96",   7'b1000000,   7'b1000000,  1'b0, 1'b1, 4'd0, 1'b0, 6'b110000);
      runPixel("blank",    7'd40,        7'd0,        1'b1, 1'b0, 4'd4, 1'b0, 6'b000000);
      runPixel("stall",    7'd40,        7'd0,        1'b1, 1'b1, 4'd4, 1'b1, 6'b100101);

`ifdef SPIRAL_CENTER_DOT_EN
      expCenter = 6'b111111;
`else
      expCenter = 6'b000011;
`endif
      runPixel("center",   7'd3,         7'd2,        1'b0, 1'b1, 4'd0, 1'b0, expCenter);

      // vsync travels the same 7-stage path; this edge leaves the counter at 1
      applyStimulus(1'b1, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, 4'd0);
      repeat (5) applyStimulus(1'b1, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      checkOutput("vs_early", {7'd0, bus.o_vsync}, 8'd0);
      applyStimulus(1'b1, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      checkOutput("vs_align", {7'd0, bus.o_vsync}, 8'd1);
      applyStimulus(1'b1, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      checkOutput("vs_after", {7'd0, bus.o_vsync}, 8'd0);

      // Counter 5 -> off 1; 253 -> off 15; 257 wraps to 1 -> off 0
      pulseVsync(4);
      runPixel("anim_5",    7'd40, 7'd0, 1'b0, 1'b1, 4'd4, 1'b0, 6'b101001);
      pulseVsync(1016);
      runPixel("anim_253",  7'd40, 7'd0, 1'b0, 1'b1, 4'd4, 1'b0, 6'b100001);
      pulseVsync(4);
      runPixel("anim_wrap", 7'd40, 7'd0, 1'b0, 1'b1, 4'd4, 1'b0, 6'b100101);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
